// File: rtl/issue_pkg.sv
// Shared encodings for the issue queue: functional-unit codes, operand-count
// codes and control-word field positions.
package issue_pkg;

    typedef enum logic [1:0] {
        FU_NONE = 2'b00,
        FU_ALU  = 2'b01,
        FU_MEM  = 2'b10,
        FU_MUL  = 2'b11
    } fu_e;

    localparam logic [1:0] NUMOP_0 = 2'b00;
    localparam logic [1:0] NUMOP_1 = 2'b01;
    localparam logic [1:0] NUMOP_2 = 2'b10;

    localparam int FUNUNIT_HI = 24;
    localparam int FUNUNIT_LO = 23;
    localparam int NUMOP_HI   = 22;
    localparam int NUMOP_LO   = 21;

    // {needs src2, needs src1}; codes 10 and 11 both take two operands
    function automatic logic [1:0] need_src(input logic [1:0] numop);
        logic [1:0] need;
        need = 2'b00;
        if (numop == NUMOP_1)
            need = 2'b01;
        else if (numop[1])
            need = 2'b11;
        return need;
    endfunction

endpackage

// File: rtl/issue_entry.sv
// One issue-queue slot: stores a decoded instruction and its operand tags,
// and sets operand-ready bits when the CDB broadcasts a matching tag.
module issue_entry #(
    parameter int CTRL_W = 25,
    parameter int TAG_W  = 4,
    parameter int ID_W   = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write,
    input  logic              clear,
    input  logic [CTRL_W-1:0] wr_ctrl,
    input  logic [ID_W-1:0]   wr_id,
    input  logic [TAG_W-1:0]  wr_src1_tag,
    input  logic              wr_src1_rdy,
    input  logic [TAG_W-1:0]  wr_src2_tag,
    input  logic              wr_src2_rdy,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [ID_W-1:0]   id,
    output logic              src1_rdy,
    output logic              src2_rdy
);

    logic [TAG_W-1:0] src1_tag;
    logic [TAG_W-1:0] src2_tag;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid    <= 1'b0;
            ctrl     <= '0;
            id       <= '0;
            src1_tag <= '0;
            src2_tag <= '0;
            src1_rdy <= 1'b0;
            src2_rdy <= 1'b0;
        end else if (write) begin
            // a broadcast in the write cycle is captured so it is not missed
            valid    <= 1'b1;
            ctrl     <= wr_ctrl;
            id       <= wr_id;
            src1_tag <= wr_src1_tag;
            src2_tag <= wr_src2_tag;
            src1_rdy <= wr_src1_rdy | (cdb_valid & (cdb_tag == wr_src1_tag));
            src2_rdy <= wr_src2_rdy | (cdb_valid & (cdb_tag == wr_src2_tag));
        end else begin
            if (clear)
                valid <= 1'b0;
            if (valid & cdb_valid & (cdb_tag == src1_tag))
                src1_rdy <= 1'b1;
            if (valid & cdb_valid & (cdb_tag == src2_tag))
                src2_rdy <= 1'b1;
        end
    end

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue: circular FIFO of decoded instructions with CDB wakeup,
// dispatching the head to ALU, load/store or multiplier via valid/ready.
import issue_pkg::*;

module issue_queue #(
    parameter int DEPTH  = 4,
    parameter int CTRL_W = 25,
    parameter int TAG_W  = 4,
    parameter int ID_W   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [ID_W-1:0]          in_id,
    input  logic [TAG_W-1:0]         in_src1_tag,
    input  logic                     in_src1_rdy,
    input  logic [TAG_W-1:0]         in_src2_tag,
    input  logic                     in_src2_rdy,
    input  logic                     cdb_valid,
    input  logic [TAG_W-1:0]         cdb_tag,
    output logic                     alu_valid,
    input  logic                     alu_ready,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic                     mul_valid,
    input  logic                     mul_ready,
    output logic [CTRL_W-1:0]        iss_ctrl,
    output logic [ID_W-1:0]          iss_id,
    output logic                     drop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              stall_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic              enq;
    logic              deq;

    logic              e_valid [DEPTH];
    logic [CTRL_W-1:0] e_ctrl  [DEPTH];
    logic [ID_W-1:0]   e_id    [DEPTH];
    logic              e_rdy1  [DEPTH];
    logic              e_rdy2  [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        issue_entry #(
            .CTRL_W(CTRL_W),
            .TAG_W (TAG_W),
            .ID_W  (ID_W)
        ) u_entry (
            .clock      (clock),
            .reset      (reset),
            .write      (enq && (tail == PTR_W'(i))),
            .clear      (deq && (head == PTR_W'(i))),
            .wr_ctrl    (in_ctrl),
            .wr_id      (in_id),
            .wr_src1_tag(in_src1_tag),
            .wr_src1_rdy(in_src1_rdy),
            .wr_src2_tag(in_src2_tag),
            .wr_src2_rdy(in_src2_rdy),
            .cdb_valid  (cdb_valid),
            .cdb_tag    (cdb_tag),
            .valid      (e_valid[i]),
            .ctrl       (e_ctrl[i]),
            .id         (e_id[i]),
            .src1_rdy   (e_rdy1[i]),
            .src2_rdy   (e_rdy2[i])
        );
    end

    logic              h_valid;
    logic [CTRL_W-1:0] h_ctrl;
    logic [1:0]        need;
    logic              ops_ok;
    fu_e               fu;

    assign h_valid  = e_valid[head];
    assign h_ctrl   = e_ctrl[head];
    assign fu       = fu_e'(h_ctrl[FUNUNIT_HI:FUNUNIT_LO]);
    assign need     = need_src(h_ctrl[NUMOP_HI:NUMOP_LO]);
    assign ops_ok   = h_valid & (~need[0] | e_rdy1[head]) & (~need[1] | e_rdy2[head]);

    assign in_ready = (count < CNT_W'(DEPTH));
    assign enq      = in_valid & in_ready;
    assign iss_ctrl = h_valid ? h_ctrl : '0;
    assign iss_id   = h_valid ? e_id[head] : '0;

    always_comb begin
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        mul_valid = 1'b0;
        drop      = 1'b0;
        case (fu)
            FU_ALU:  alu_valid = ops_ok;
            FU_MEM:  mem_valid = ops_ok;
            FU_MUL:  mul_valid = ops_ok;
            default: drop      = h_valid;
        endcase
        deq = drop | (alu_valid & alu_ready) | (mem_valid & mem_ready) | (mul_valid & mul_ready);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            stall_cnt <= '0;
        end else begin
            if (enq)
                tail <= tail + PTR_W'(1);
            if (deq)
                head <= head + PTR_W'(1);
            case ({enq, deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (h_valid && !deq && stall_cnt != '1)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Randomized bench for issue_queue against a queue-based behavioural model,
// with directed scenarios pinned by literal expectations.
module tb_issue_queue;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] in_ctrl;
    logic [3:0]  in_id;
    logic [3:0]  in_src1_tag;
    logic        in_src1_rdy;
    logic [3:0]  in_src2_tag;
    logic        in_src2_rdy;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic        alu_valid, alu_ready;
    logic        mem_valid, mem_ready;
    logic        mul_valid, mul_ready;
    logic [24:0] iss_ctrl;
    logic [3:0]  iss_id;
    logic        drop;
    logic [2:0]  count;
    logic [15:0] stall_cnt;

    always #5 clock = ~clock;

    issue_queue #(.DEPTH(DEPTH), .CTRL_W(25), .TAG_W(4), .ID_W(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_id(in_id),
        .in_src1_tag(in_src1_tag), .in_src1_rdy(in_src1_rdy),
        .in_src2_tag(in_src2_tag), .in_src2_rdy(in_src2_rdy),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mul_valid(mul_valid), .mul_ready(mul_ready),
        .iss_ctrl(iss_ctrl), .iss_id(iss_id), .drop(drop),
        .count(count), .stall_cnt(stall_cnt)
    );

    typedef struct {
        logic [24:0] ctrl;
        logic [3:0]  id;
        logic [3:0]  t1, t2;
        logic        r1, r2;
    } ent_t;

    ent_t        q[$];
    int unsigned m_stall = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Check current outputs against the model, then advance model and DUT one clock.
    task automatic tick();
        logic [1:0]  fu, nop;
        logic        ok, ea, em, eu, ed, deq, enq;
        logic [24:0] ectrl;
        logic [3:0]  eid;
        ent_t        h, n;
        #1;
        if (reset) begin
            q.delete();
            m_stall = 0;
        end
        ea = 0; em = 0; eu = 0; ed = 0; ectrl = '0; eid = '0;
        if (q.size() > 0) begin
            h   = q[0];
            fu  = h.ctrl[24:23];
            nop = h.ctrl[22:21];
            ok  = (nop == 2'd0) || (nop == 2'd1 && h.r1) || (nop >= 2'd2 && h.r1 && h.r2);
            ea  = ok && fu == 2'd1;
            em  = ok && fu == 2'd2;
            eu  = ok && fu == 2'd3;
            ed  = (fu == 2'd0);
            ectrl = h.ctrl;
            eid   = h.id;
        end
        chk("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
        chk("count",     32'(count),     32'(q.size()));
        chk("alu_valid", 32'(alu_valid), 32'(ea));
        chk("mem_valid", 32'(mem_valid), 32'(em));
        chk("mul_valid", 32'(mul_valid), 32'(eu));
        chk("drop",      32'(drop),      32'(ed));
        chk("iss_ctrl",  32'(iss_ctrl),  32'(ectrl));
        chk("iss_id",    32'(iss_id),    32'(eid));
        chk("stall_cnt", 32'(stall_cnt), m_stall);
        if (!reset) begin
            deq = ed || (ea && alu_ready) || (em && mem_ready) || (eu && mul_ready);
            enq = in_valid && (q.size() < DEPTH);
            if (cdb_valid)
                foreach (q[i]) begin
                    if (q[i].t1 == cdb_tag) q[i].r1 = 1'b1;
                    if (q[i].t2 == cdb_tag) q[i].r2 = 1'b1;
                end
            if (q.size() > 0 && !deq && m_stall < 65535)
                m_stall++;
            if (deq)
                q.delete(0);
            if (enq) begin
                n.ctrl = in_ctrl;
                n.id   = in_id;
                n.t1   = in_src1_tag;
                n.t2   = in_src2_tag;
                n.r1   = in_src1_rdy || (cdb_valid && cdb_tag == in_src1_tag);
                n.r2   = in_src2_rdy || (cdb_valid && cdb_tag == in_src2_tag);
                q.push_back(n);
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle();
        in_valid = 0; in_ctrl = '0; in_id = '0;
        in_src1_tag = '0; in_src1_rdy = 0; in_src2_tag = '0; in_src2_rdy = 0;
        cdb_valid = 0; cdb_tag = '0;
        alu_ready = 0; mem_ready = 0; mul_ready = 0;
    endtask

    task automatic offer(input logic [1:0] fu, input logic [1:0] nop, input logic [3:0] id,
                         input logic [3:0] t1, input logic r1, input logic [3:0] t2, input logic r2);
        in_valid = 1; in_ctrl = {fu, nop, 21'h0ABCD}; in_id = id;
        in_src1_tag = t1; in_src1_rdy = r1; in_src2_tag = t2; in_src2_rdy = r2;
    endtask

    initial begin
        idle();
        reset = 1;
        @(negedge clock);
        tick();
        reset = 0;
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);

        // reset mid-operation with three stalled entries
        offer(2'b01, 2'b10, 4'd1, 4'd15, 0, 4'd15, 0);
        repeat (3) tick();
        in_valid = 0;
        chk("s1_count3", 32'(count), 3);
        reset = 1;
        tick();
        chk("s1_count0", 32'(count), 0);
        chk("s1_alu", 32'(alu_valid), 0);
        chk("s1_in_ready", 32'(in_ready), 1);
        chk("s1_stall", 32'(stall_cnt), 0);
        reset = 0;
        tick();

        // ALU with both operands ready
        offer(2'b01, 2'b10, 4'd2, 4'd1, 1, 4'd2, 1);
        alu_ready = 1;
        tick();
        in_valid = 0;
        chk("s2_alu", 32'(alu_valid), 1);
        chk("s2_id", 32'(iss_id), 2);
        tick();
        chk("s2_count", 32'(count), 0);

        // multiplier waiting on CDB tag 5
        idle();
        mul_ready = 1;
        offer(2'b11, 2'b10, 4'd3, 4'd1, 1, 4'd5, 0);
        tick();
        in_valid = 0;
        chk("s3_mul0", 32'(mul_valid), 0);
        tick();
        chk("s3_stall1", 32'(stall_cnt), 1);
        cdb_valid = 1; cdb_tag = 4'd5;
        tick();
        cdb_valid = 0;
        chk("s3_mul1", 32'(mul_valid), 1);
        chk("s3_stall2", 32'(stall_cnt), 2);
        tick();
        chk("s3_count", 32'(count), 0);

        // same-cycle CDB capture on enqueue
        idle();
        mem_ready = 1;
        offer(2'b10, 2'b01, 4'd4, 4'd3, 0, 4'd0, 0);
        cdb_valid = 1; cdb_tag = 4'd3;
        tick();
        in_valid = 0; cdb_valid = 0;
        chk("s4_mem", 32'(mem_valid), 1);
        tick();
        chk("s4_count", 32'(count), 0);

        // full queue, no bypass
        idle();
        offer(2'b10, 2'b00, 4'd6, 4'd0, 0, 4'd0, 0);
        repeat (4) tick();
        chk("s5_count4", 32'(count), 4);
        chk("s5_in_ready0", 32'(in_ready), 0);
        chk("s5_mem", 32'(mem_valid), 1);
        tick();
        chk("s5_still4", 32'(count), 4);
        mem_ready = 1;
        tick();
        chk("s5_count3", 32'(count), 3);
        chk("s5_in_ready1", 32'(in_ready), 1);
        in_valid = 0;
        repeat (3) tick();
        chk("s5_empty", 32'(count), 0);

        // fununit 00 drop, with and without concurrent enqueue
        idle();
        offer(2'b00, 2'b10, 4'd7, 4'd9, 0, 4'd9, 0);
        tick();
        chk("s6_drop", 32'(drop), 1);
        chk("s6_novalid", 32'({alu_valid, mem_valid, mul_valid}), 0);
        chk("s6_count1", 32'(count), 1);
        tick();
        in_valid = 0;
        chk("s6_count_same", 32'(count), 1);
        chk("s6_drop2", 32'(drop), 1);
        tick();
        chk("s6_count0", 32'(count), 0);
        chk("s6_drop0", 32'(drop), 0);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset       = ($urandom_range(0, 399) == 0);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_ctrl     = 25'($urandom);
            in_id       = 4'($urandom);
            in_src1_tag = 4'($urandom_range(0, 3));
            in_src1_rdy = ($urandom_range(0, 2) == 0);
            in_src2_tag = 4'($urandom_range(0, 3));
            in_src2_rdy = ($urandom_range(0, 2) == 0);
            cdb_valid   = ($urandom_range(0, 4) < 2);
            cdb_tag     = 4'($urandom_range(0, 3));
            alu_ready   = ($urandom_range(0, 1) == 0);
            mem_ready   = ($urandom_range(0, 1) == 0);
            mul_ready   = ($urandom_range(0, 1) == 0);
            tick();
        end
        reset = 0;
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
